// File: rtl/pwm_pkg.sv
// Shared constants, count type and ramp-step helper for the PWM ramp block.
package pwm_pkg;

  localparam int unsigned CNT_W        = 12;
  localparam int unsigned PERIOD       = 4096;
  localparam int unsigned STEP_DEF     = 16;
  localparam int unsigned RAMP_DIV_DEF = 1;
  localparam int unsigned PRESC_DEF    = 1;

  typedef logic [CNT_W-1:0] count_t;

  // One ramp move of cur toward tgt, limited to step counts.
  // The difference is held one bit wider and signed, so neither direction
  // can leave 0..PERIOD-1.
  function automatic count_t ramp_next(input count_t cur, input count_t tgt,
                                       input int unsigned step);
    logic signed [CNT_W:0] diff;
    logic signed [CNT_W:0] lim;
    count_t                stp;
    count_t                res;
    res  = tgt;
    stp  = count_t'(step);
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    lim  = $signed({1'b0, stp});
    if (step < PERIOD) begin
      if (diff > lim) begin
        res = cur + stp;
      end else if (diff < -lim) begin
        res = cur - stp;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_counter.sv
// Prescaler and free-running period counter with boundary and period-start strobes.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int unsigned PRESC = PRESC_DEF
) (
  input  logic   clk,
  input  logic   reset,
  output count_t o_cnt,
  output logic   o_boundary,
  output logic   o_period_start
);

  localparam int unsigned     PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC - 1);
  localparam count_t          CNT_LAST   = count_t'(PERIOD - 1);

  logic [PW-1:0] r_presc;
  count_t        r_cnt;
  logic          r_period_start;
  logic          w_tick;
  logic          w_boundary;

  // Prescaler starts at zero, so the first tick lands PRESC clocks after reset.
  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_boundary = w_tick && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc        <= '0;
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_cnt   <= r_cnt + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_period_start <= w_boundary;
    end
  end

  assign o_cnt          = r_cnt;
  assign o_boundary     = w_boundary;
  assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_ramp.sv
// PWM generator whose applied duty ramps toward the target once per RAMP_DIV periods.
module pwm_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned PRESC    = PRESC_DEF,
  parameter int unsigned STEP     = STEP_DEF,
  parameter int unsigned RAMP_DIV = RAMP_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] duty,
  input  logic             fault,
  output logic             pulse,
  output logic [CNT_W-1:0] duty_cur,
  output logic             at_target,
  output logic             period_start
);

  localparam int unsigned   DW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);

  count_t        w_cnt;
  logic          w_boundary;
  logic          w_ramp_due;
  count_t        w_duty_next;

  count_t        r_duty_cur;
  count_t        r_cmp;
  logic [DW-1:0] r_div;
  logic          r_pulse;

  pwm_counter #(
    .PRESC(PRESC)
  ) u_counter (
    .clk           (clk),
    .reset         (reset),
    .o_cnt         (w_cnt),
    .o_boundary    (w_boundary),
    .o_period_start(period_start)
  );

  assign w_ramp_due  = (r_div == DIV_LAST);
  assign w_duty_next = ramp_next(r_duty_cur, duty, STEP);

  // Fault outranks the boundary, so a fault on the wrap tick loads cmp with 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_duty_cur <= '0;
      r_cmp      <= '0;
      r_div      <= '0;
      r_pulse    <= 1'b0;
    end else if (fault) begin
      r_duty_cur <= '0;
      r_cmp      <= '0;
      r_div      <= '0;
      r_pulse    <= 1'b0;
    end else begin
      r_pulse <= (w_cnt < r_cmp);
      if (w_boundary) begin
        if (w_ramp_due) begin
          r_div      <= '0;
          r_duty_cur <= w_duty_next;
          r_cmp      <= w_duty_next;
        end else begin
          r_div <= r_div + 1'b1;
          r_cmp <= r_duty_cur;
        end
      end
    end
  end

  assign pulse     = r_pulse;
  assign duty_cur  = r_duty_cur;
  assign at_target = (r_duty_cur == duty) && !fault;

endmodule
